// File: rtl/serial_rx_pkg.sv
// rtl/serial_rx_pkg.sv - shared types and helpers for the serial receive sampler (SERIAL_RX_MAJORITY_EN)
package serial_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BRK
   } rx_state_t;

   // Bit period in pclk ticks, rounded to nearest
   function automatic int bit_ticks(input int cf, input int sr);
      return (cf + sr / 2) / sr;
   endfunction

   // Tick counter width for a given bit period
   function automatic int cnt_width(input int n);
      return $clog2(n + 2);
   endfunction

   // Majority voting takes its decision one tick after the nominal centre
`ifdef SERIAL_RX_MAJORITY_EN
   localparam int SAMPLE_LAG = 1;
`else
   localparam int SAMPLE_LAG = 0;
`endif

endpackage

// File: rtl/serial_rx_sync.sv
// rtl/serial_rx_sync.sv - two-flop line synchronizer and start-arming logic
module serial_rx_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic pclk,
   input  logic rx_serial,
   input  logic in_idle,
   output logic rx_s,
   output logic armed
);

   logic [1:0] sync_q, sync_d;
   logic [1:0] prime_q, prime_d;
   logic       armed_q, armed_d;

   // Shift the raw line in; arm only once the line has genuinely been seen high
   // after reset (prime covers the two cycles where sync still shows its reset value)
   always_comb begin
      sync_d  = {sync_q[0], rx_serial};
      prime_d = {prime_q[0], 1'b1};
      armed_d = armed_q;
      if (pclk && in_idle && prime_q[1] && sync_q[1]) begin
         armed_d = 1'b1;
      end
   end

   // State registers, line-high on reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= 2'b11;
         prime_q <= 2'b00;
         armed_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         prime_q <= prime_d;
         armed_q <= armed_d;
      end
   end

   assign rx_s  = sync_q[1];
   assign armed = armed_q;

endmodule

// File: rtl/serial_rx_sampler.sv
// rtl/serial_rx_sampler.sv - 8N1 receive front-end with mid-bit sampling (SERIAL_RX_MAJORITY_EN)
module serial_rx_sampler
   import serial_rx_pkg::*;
#(
   parameter int clk_freq = 3333333,
   parameter int sym_rate = 115200
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pclk,
   input  logic       rx_serial,
   output logic [7:0] rx_dat,
   output logic       rx_stb,
   output logic       rx_err
);

   localparam int N        = bit_ticks(clk_freq, sym_rate);
   localparam int H        = N / 2;
   localparam int CW       = cnt_width(N);
   localparam int START_PT = H + SAMPLE_LAG;
   localparam logic [CW-1:0] START_LAST = CW'(START_PT - 1);
   localparam logic [CW-1:0] BIT_LAST   = CW'(N - 1);

   if (N < 4) begin : g_bad_n
      $error("serial_rx_sampler: bit period must be at least 4 pclk ticks");
   end

   rx_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bits_q, bits_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [7:0]    dat_q, dat_d;
   logic          stb_q, stb_d;
   logic          err_q, err_d;
   logic          rx_s;
   logic          armed;
   logic          samp;

   serial_rx_sync u_sync (
      .clk       (clk),
      .reset_n   (reset_n),
      .pclk      (pclk),
      .rx_serial (rx_serial),
      .in_idle   (state_q == ST_IDLE),
      .rx_s      (rx_s),
      .armed     (armed)
   );

`ifdef SERIAL_RX_MAJORITY_EN
   logic [1:0] hist_q, hist_d;

   // Remember the two previous tick samples for the 2-of-3 vote
   always_comb begin
      hist_d = hist_q;
      if (pclk) begin
         hist_d = {hist_q[0], rx_s};
      end
   end

   // History register, line-high on reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist_q <= 2'b11;
      end else begin
         hist_q <= hist_d;
      end
   end

   assign samp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
   assign samp = rx_s;
`endif

   // Frame FSM: the counter holds ticks-since-reference minus one, all moves gated by pclk
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bits_d  = bits_q;
      shreg_d = shreg_q;
      dat_d   = dat_q;
      stb_d   = stb_q;
      err_d   = err_q;
      if (pclk) begin
         stb_d = 1'b0;
         cnt_d = cnt_q + 1'b1;
         case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
               if (armed && !rx_s) begin
                  state_d = ST_START;
               end
            end
            ST_START: begin
               if (cnt_q == START_LAST) begin
                  cnt_d   = '0;
                  bits_d  = 3'd0;
                  state_d = samp ? ST_IDLE : ST_DATA;
               end
            end
            ST_DATA: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_d   = '0;
                  shreg_d = {samp, shreg_q[7:1]};
                  bits_d  = bits_q + 3'd1;
                  if (bits_q == 3'd7) begin
                     state_d = ST_STOP;
                  end
               end
            end
            ST_STOP: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_d   = '0;
                  dat_d   = shreg_q;
                  stb_d   = 1'b1;
                  err_d   = ~samp;
                  state_d = samp ? ST_IDLE : ST_BRK;
               end
            end
            ST_BRK: begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bits_q  <= 3'd0;
         shreg_q <= 8'h00;
         dat_q   <= 8'h00;
         stb_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bits_q  <= bits_d;
         shreg_q <= shreg_d;
         dat_q   <= dat_d;
         stb_q   <= stb_d;
         err_q   <= err_d;
      end
   end

   assign rx_dat = dat_q;
   assign rx_stb = stb_q;
   assign rx_err = err_q;

endmodule

// File: tb/tb_serial_rx_sampler.sv
// tb/tb_serial_rx_sampler.sv - directed bench for serial_rx_sampler (SERIAL_RX_MAJORITY_EN adds spike test)
module tb_serial_rx_sampler;

   localparam int CLK_FREQ = 3333333;
   localparam int SYM_RATE = 115200;
   localparam int N        = 29;
   localparam int NV       = 12;

   logic       clk;
   logic       reset_n;
   logic       pclk;
   logic       rx_serial;
   logic [7:0] rx_dat;
   logic       rx_stb;
   logic       rx_err;

   serial_rx_sampler #(
      .clk_freq (CLK_FREQ),
      .sym_rate (SYM_RATE)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .pclk      (pclk),
      .rx_serial (rx_serial),
      .rx_dat    (rx_dat),
      .rx_stb    (rx_stb),
      .rx_err    (rx_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // pclk is high for every other clk cycle, changing away from both clk edges
   initial begin
      pclk = 1'b0;
      #11;
      forever begin
         pclk = 1'b1;
         #10;
         pclk = 1'b0;
         #10;
      end
   end

   typedef struct packed {
      logic [7:0] dat;
      logic       err;
   } obs_t;

   obs_t got_q[$];
   obs_t exp_q[$];

   // Consumer view: record every pclk cycle that carries a strobe
   always @(negedge clk) begin
      if (pclk && rx_stb) got_q.push_back({rx_dat, rx_err});
   end

   typedef struct {
      int         kind;       // 0 = frame, 1 = low pulse
      logic [7:0] data;
      logic       stop;
      int         tail_low;
      int         low_ticks;
      real        per;
      int         gap;
      logic       exp_stb;
      logic [7:0] exp_dat;
      logic       exp_err;
   } vec_t;

   vec_t vecs[NV];
   int   checks = 0;
   int   errors = 0;
   logic [7:0] last_dat;
   logic       last_err;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         while (pclk !== 1'b1) @(posedge clk);
      end
      #1;
   endtask

   task automatic drain(input string tag);
      obs_t g;
      obs_t e;
      chk({tag, "_count"}, got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         chk({tag, "_dat"}, g.dat, e.dat);
         chk({tag, "_err"}, g.err, e.err);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input real per,
                             input int tail_low, input bit spike);
      logic v;
      int   len;
      for (int i = 0; i < 10; i++) begin
         v   = (i == 0) ? 1'b0 : (i == 9) ? stop : d[i-1];
         len = $rtoi(per * (i + 1) + 0.5) - $rtoi(per * i + 0.5);
         if (spike && i > 0 && i < 9) begin
            rx_serial = v;
            tick(len / 2);
            rx_serial = ~v;
            tick(1);
            rx_serial = v;
            tick(len - len / 2 - 1);
         end else begin
            rx_serial = v;
            tick(len);
         end
      end
      if (tail_low > 0) begin
         rx_serial = 1'b0;
         tick(tail_low);
      end
      rx_serial = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{0, 8'h55, 1'b1, 0, 0,      29.0,  2*N, 1'b1, 8'h55, 1'b0};
      vecs[1]  = '{1, 8'h00, 1'b1, 0, N/4,    29.0,  2*N, 1'b0, 8'h00, 1'b0};
      vecs[2]  = '{0, 8'hA5, 1'b0, N, 0,      29.0,  2*N, 1'b1, 8'hA5, 1'b1};
      vecs[3]  = '{0, 8'h3C, 1'b1, 0, 0,      29.0,  2*N, 1'b1, 8'h3C, 1'b0};
      vecs[4]  = '{1, 8'h00, 1'b1, 0, 20*N,   29.0,  2*N, 1'b1, 8'h00, 1'b1};
      vecs[5]  = '{0, 8'hFF, 1'b1, 0, 0,      29.0,  2*N, 1'b1, 8'hFF, 1'b0};
      vecs[6]  = '{0, 8'h00, 1'b1, 0, 0,      29.87, 0,   1'b1, 8'h00, 1'b0};
      vecs[7]  = '{0, 8'hFF, 1'b1, 0, 0,      29.87, 0,   1'b1, 8'hFF, 1'b0};
      vecs[8]  = '{0, 8'h81, 1'b1, 0, 0,      29.87, 2*N, 1'b1, 8'h81, 1'b0};
      vecs[9]  = '{0, 8'h00, 1'b1, 0, 0,      28.13, 0,   1'b1, 8'h00, 1'b0};
      vecs[10] = '{0, 8'hFF, 1'b1, 0, 0,      28.13, 0,   1'b1, 8'hFF, 1'b0};
      vecs[11] = '{0, 8'h81, 1'b1, 0, 0,      28.13, 2*N, 1'b1, 8'h81, 1'b0};

      rx_serial = 1'b1;
      reset_n   = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("reset_dat", rx_dat, 8'h00);
      chk("reset_stb", rx_stb, 1'b0);
      chk("reset_err", rx_err, 1'b0);
      last_dat = 8'h00;
      last_err = 1'b0;
      reset_n  = 1'b1;
      tick(2 * N);

      for (int i = 0; i < NV; i++) begin
         if (vecs[i].kind == 0) begin
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].per, vecs[i].tail_low, 1'b0);
         end else begin
            rx_serial = 1'b0;
            tick(vecs[i].low_ticks);
            rx_serial = 1'b1;
         end
         if (vecs[i].exp_stb) begin
            exp_q.push_back({vecs[i].exp_dat, vecs[i].exp_err});
            last_dat = vecs[i].exp_dat;
            last_err = vecs[i].exp_err;
         end
         if (vecs[i].gap > 0) begin
            tick(vecs[i].gap);
            drain($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_hold_dat", i), rx_dat, last_dat);
            chk($sformatf("vec%0d_hold_err", i), rx_err, last_err);
            chk($sformatf("vec%0d_stb_low", i), rx_stb, 1'b0);
         end
      end

      // Reset in the middle of data bit 4, line kept low through release
      rx_serial = 1'b0;
      tick(N);
      tick(4 * N);
      rx_serial = 1'b1;
      tick(N / 2);
      #3;
      reset_n   = 1'b0;
      rx_serial = 1'b0;
      tick(4);
      chk("midrst_dat", rx_dat, 8'h00);
      chk("midrst_stb", rx_stb, 1'b0);
      chk("midrst_err", rx_err, 1'b0);
      reset_n = 1'b1;
      tick(3 * N);
      drain("rst_low");
      chk("rst_low_dat", rx_dat, 8'h00);
      chk("rst_low_err", rx_err, 1'b0);

      rx_serial = 1'b1;
      tick(N);
      send_frame(8'h42, 1'b1, 29.0, 0, 1'b0);
      exp_q.push_back({8'h42, 1'b0});
      tick(2 * N);
      drain("after_rst");

`ifdef SERIAL_RX_MAJORITY_EN
      send_frame(8'hC9, 1'b1, 29.0, 0, 1'b1);
      exp_q.push_back({8'hC9, 1'b0});
      tick(2 * N);
      drain("spike");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_rx_sampler.md
# serial_rx_sampler

Asynchronous serial receive front-end for the 6502 ACIA peripheral. It synchronizes the raw `rx` pin, detects and validates start bits, and recovers 8N1 frames by sampling at mid-bit on the `pclk` enable grid. Each completed frame is delivered as `rx_dat`/`rx_stb`/`rx_err` to the ACIA register block, which sits directly downstream and samples the strobe only on `pclk` cycles.

## Interface
Parameters:
- `clk_freq`, 3333333: rate of `pclk` enable pulses in Hz.
- `sym_rate`, 115200: baud rate in symbols per second.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `pclk`  in  1  peripheral clock enable, one `clk` wide, `clk_freq` rate.
- `rx_serial`  in  1  raw serial line, idle high, asynchronous.
- `rx_dat`  out  8  last received byte.
- `rx_stb`  out  1  frame-complete strobe.
- `rx_err`  out  1  framing error of the last frame.

## Operation
- Bit period `N = (clk_freq + sym_rate/2) / sym_rate` in `pclk` ticks; half period `H = N/2` (floor).
- `N < 4` is an elaboration error.
- Synchronizer: 2 flops on every `clk`, both reset to 1. All other state advances only on `clk` edges where `pclk=1`.
- `armed` flag:
  - Reset 0.
  - Set in IDLE when the synchronized line is high.
  - A line held low through reset release never starts a frame.
- States: IDLE, START, DATA, STOP, BRK.
  - IDLE: when `armed` and the line is low, clear the tick counter and go to START.
  - START: at sample point H, a high sample means a glitch: return to IDLE, no strobe. A low sample goes to DATA.
  - DATA: 8 bits, LSB first, each sampled N ticks after the previous sample point, shifted into the shift register.
  - STOP: at the next sample point, load `rx_dat` from the shift register, assert `rx_stb`, and set `rx_err` to the inverse of the stop sample. A high stop goes to IDLE; a low stop goes to BRK.
  - BRK: wait for the line to go high, then IDLE. No further strobes are issued while in BRK.
- `rx_stb` is registered. It is high from the strobing `pclk` edge until the next `pclk`-enabled edge, so the consumer sees exactly one `pclk=1` cycle with `rx_stb=1`.
- `rx_dat` and `rx_err` are held until the next strobe.
- A break (line held low for 10 or more bits) yields one strobe with `rx_dat=0x00`, `rx_err=1`.
- Back-to-back frames: the next start bit may be detected on the first IDLE tick after STOP.
- Reset asserted mid-frame: immediate return to IDLE, all outputs 0, `armed=0`, frame discarded.

## Timing
- Reset values: `rx_dat=0x00`, `rx_stb=0`, `rx_err=0`, state IDLE.
- Sample points, counted from the start-detect tick: start at H, data bit k at H+(k+1)N, stop at H+9N.
- The strobe becomes visible 1 `clk` after the stop sample tick.
- Total latency from the line's falling edge is 2 `clk` + at most 1 `pclk` tick + H+9N ticks.
- Receive tolerance: ±3% baud mismatch at N ≥ 16.

## Configuration
`SERIAL_RX_MAJORITY_EN`:
- Defined: each sample point, including start and stop, is the 2-of-3 majority of ticks center-1, center, center+1. The decision is taken at center+1, and all sample/strobe times above shift by +1 tick.
- Undefined: a single sample at center.

## Structure
- Package `serial_rx_pkg`:
  - State enum `rx_state_t`.
  - Function `bit_ticks(clk_freq, sym_rate)` returning N.
  - Counter width constant `$clog2(N+2)`.
- Sub-module `serial_rx_sync`: 2-flop synchronizer plus `armed` logic, with async reset to line-high.

## Test plan
- Send 0x55 at 115200 with `clk_freq`=3333333 (N=29) -> one strobe, `rx_dat=0x55`, `rx_err=0`, `rx_stb` high for exactly one `pclk` period.
- Low glitch of 0.25 bit, then idle -> no strobe, state back to IDLE, outputs unchanged.
- 0xA5 with the stop bit forced low, then line high after 2 bits -> one strobe, `rx_dat=0xA5`, `rx_err=1`. Next frame 0x3C -> `rx_err=0`.
- Line low for 20 bit times -> exactly one strobe with `rx_dat=0x00`, `rx_err=1`. Following 0xFF received correctly.
- Back-to-back 0x00, 0xFF, 0x81 with no idle gap, at sym_rate ±3% -> three strobes with the correct bytes and `rx_err=0`.
- Reset asserted at data bit 4, then line held low through reset release -> outputs 0, no frame. Line high for 1 bit then 0x42 -> `rx_dat=0x42`. With the macro defined, a 1-tick mid-bit spike on each data bit -> byte still correct.
